// File: rtl/diad_trace_tx_pkg.sv
// diad_trace_tx_pkg: shared constants and types for the diad trace transmitter.
//   - frame sync bytes (normal and "records were lost before this one")
//   - FSM state encoding for the byte serialiser
//   - field_bytes(): number of stream bytes needed to carry a field of N bits
package diad_trace_tx_pkg;

    localparam logic [7:0] TRACE_SYNC_OK   = 8'hA5;
    localparam logic [7:0] TRACE_SYNC_LOSS = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_TICK  = 3'd2,
        ST_PC    = 3'd3,
        ST_INSTR = 3'd4
    } trace_state_e;

    // Bytes needed to carry a field, rounding partial bytes up (zero-padded).
    function automatic int unsigned field_bytes(input int unsigned width_bits);
        return (width_bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/diad_trace_tx_if.sv
// diad_trace_tx_if: valid/ready byte stream carrying trace frames off the core.
//   ow_tx_data   : stream byte
//   ow_tx_valid  : ow_tx_data is valid
//   iw_tx_ready  : sink accepts the byte (transfer when valid & ready)
// master = transmitter side, slave = sink side.
interface diad_trace_tx_if;

    logic [7:0] ow_tx_data;
    logic       ow_tx_valid;
    logic       iw_tx_ready;

    modport master (
        output ow_tx_data,
        output ow_tx_valid,
        input  iw_tx_ready
    );

    modport slave (
        input  ow_tx_data,
        input  ow_tx_valid,
        output iw_tx_ready
    );

endinterface

// File: rtl/diad_trace_tx_fifo.sv
// diad_trace_tx_fifo: synchronous record FIFO for the trace transmitter.
//   clk       : clock
//   rst_n     : synchronous reset, active-low (empties the FIFO)
//   push      : write push_data (ignored when full unless popping this cycle)
//   push_data : record to store
//   pop       : consume the head entry (ignored when empty)
//   rd_data   : head entry, read straight out of the storage flops
//   full      : DEPTH entries held
//   empty     : no entries held
// A pop in the same cycle as a push while full frees the slot first, so the
// push is accepted.
module diad_trace_tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == {(PTR_W + 1){1'b0}});
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointer and occupancy values; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/diad_trace_tx.sv
// diad_trace_tx: debug trace transmitter for the diad core.
// Captures {tick, WB pc, WB instr} on every retirement while tracing is
// enabled, queues records in a small FIFO and serialises each as a frame
//   SYNC | TICK (LSB first) | PC (LSB first) | INSTR (LSB first)
// on a valid/ready byte stream. SYNC is 8'h5A instead of 8'hA5 when records
// were dropped (FIFO full) before this one was dequeued.
// Ports:
//   iw_clk        : core clock
//   iw_rst        : synchronous reset, active-low
//   iw_trace_en   : capture enable (queued records still drain when low)
//   iw_wb_valid   : WB retires an instruction this cycle
//   iw_wb_pc      : WB PC
//   iw_wb_instr   : WB instruction
//   tx            : byte stream (master side)
//   ow_drop_cnt   : saturating count of dropped records
//   ow_busy       : FIFO non-empty or a frame in flight
module diad_trace_tx
    import diad_trace_tx_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int INSTR_W = 24,
    parameter int TICK_W  = 16,
    parameter int DEPTH   = 8
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_trace_en,
    input  logic               iw_wb_valid,
    input  logic [ADDR_W-1:0]  iw_wb_pc,
    input  logic [INSTR_W-1:0] iw_wb_instr,
    diad_trace_tx_if.master    tx,
    output logic [7:0]         ow_drop_cnt,
    output logic               ow_busy
);

    localparam int TICK_B  = TICK_W / 8;
    localparam int PC_B    = int'(field_bytes(ADDR_W));
    localparam int INSTR_B = int'(field_bytes(INSTR_W));
    localparam int REC_W   = TICK_W + ADDR_W + INSTR_W;
    localparam int SH_W    = 8 * (TICK_B + PC_B + INSTR_B);

    localparam logic [7:0] TICK_LAST  = 8'(TICK_B - 1);
    localparam logic [7:0] PC_LAST    = 8'(PC_B - 1);
    localparam logic [7:0] INSTR_LAST = 8'(INSTR_B - 1);

    trace_state_e     state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             loss_q, loss_d;

    logic             capture;
    logic             drop;
    logic             accept;
    logic             frame_end;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_rd;
    logic [SH_W-1:0]  payload;

    assign capture   = iw_trace_en & iw_wb_valid;
    // A pop this cycle frees a slot, so only a full FIFO without a pop drops.
    assign drop      = capture & fifo_full & ~fifo_pop;
    assign accept    = tx_valid_q & tx.iw_tx_ready;
    assign frame_end = accept & (state_q == ST_INSTR) & (cnt_q == INSTR_LAST);

    // Frame payload laid out so the first byte to send sits in the low byte.
    assign payload = {(8 * INSTR_B)'(fifo_rd[TICK_W + ADDR_W +: INSTR_W]),
                      (8 * PC_B)'(fifo_rd[TICK_W +: ADDR_W]),
                      fifo_rd[TICK_W-1:0]};

    diad_trace_tx_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (iw_clk),
        .rst_n     (iw_rst),
        .push      (capture),
        .push_data ({iw_wb_instr, iw_wb_pc, tick_q}),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Serialiser next state: load a record when idle or as the previous frame
    // ends (no gap), otherwise advance one byte per accepted transfer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        fifo_pop   = 1'b0;
        if (((state_q == ST_IDLE) | frame_end) & ~fifo_empty) begin
            fifo_pop   = 1'b1;
            state_d    = ST_SYNC;
            cnt_d      = 8'd0;
            shift_d    = payload;
            tx_data_d  = loss_q ? TRACE_SYNC_LOSS : TRACE_SYNC_OK;
            tx_valid_d = 1'b1;
        end else if (frame_end) begin
            state_d    = ST_IDLE;
            cnt_d      = 8'd0;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
        end else if (accept) begin
            tx_data_d = shift_q[7:0];
            shift_d   = shift_q >> 4'd8;
            case (state_q)
                ST_SYNC: begin
                    state_d = ST_TICK;
                    cnt_d   = 8'd0;
                end
                ST_TICK: begin
                    if (cnt_q == TICK_LAST) begin
                        state_d = ST_PC;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_PC: begin
                    if (cnt_q == PC_LAST) begin
                        state_d = ST_INSTR;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_INSTR: begin
                    cnt_d = cnt_q + 8'd1;
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = 8'd0;
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Tick, drop counter and loss flag next values.
    always_comb begin
        tick_d     = tick_q + TICK_W'(1);
        drop_cnt_d = drop_cnt_q;
        loss_d     = loss_q;
        if (drop) begin
            loss_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (fifo_pop) begin
            loss_d = 1'b0;
        end else begin
            loss_d = loss_q;
        end
    end

    // Serialiser and status registers; reset abandons any frame in flight.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            shift_q    <= {SH_W{1'b0}};
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tick_q     <= {TICK_W{1'b0}};
            drop_cnt_q <= 8'd0;
            loss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tick_q     <= tick_d;
            drop_cnt_q <= drop_cnt_d;
            loss_q     <= loss_d;
        end
    end

    assign tx.ow_tx_data  = tx_data_q;
    assign tx.ow_tx_valid = tx_valid_q;
    assign ow_drop_cnt    = drop_cnt_q;
    assign ow_busy        = ~fifo_empty | (state_q != ST_IDLE);

endmodule
